computer_system_fp_command: RTL

Avalon-MM write-side command port that lets the HPS load two IEEE-754 single-precision operands and an opcode, then launch one floating-point operation on the NPU FP datapath. It sits between the lightweight HPS bridge and the FP unit. It drives operands with a valid/ready handshake, tracks the operation until the FP unit signals completion, and raises a sticky done flag and optional IRQ. The numeric result itself is returned to the HPS through the read-only FP result port.

---
 rtl/computer_system_fp_command.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/computer_system_fp_command.sv
// -----------------------------------------------------------------------------
// computer_system_fp_command
//
// Avalon-MM command port between the lightweight HPS bridge and the NPU FP
// datapath. The HPS loads two single-precision operands and an opcode, then
// launches one operation. The block presents the command to the FP unit with
// a valid/ready handshake and tracks it until the FP unit pulses result_valid.
// At that point it raises a sticky done flag and, if enabled, an interrupt.
// The numeric result is returned through a separate read-only result port.
//
// Ports:
//   clk           system clock
//   reset         synchronous reset, active-high
//   address       register word select (0 OPA, 1 OPB, 2 CTRL, 3 STATUS)
//   chipselect    slave select
//   write_n       active-low write strobe
//   writedata     write data
//   readdata      registered read data (address mux captured every cycle)
//   op_a, op_b    operands to the FP unit
//   opcode        operation select to the FP unit
//   cmd_valid     command valid to the FP unit
//   cmd_ready     FP unit accepts the command
//   result_valid  one-cycle completion pulse from the FP unit
//   irq           interrupt, equal to done && irq_en
// -----------------------------------------------------------------------------
module computer_system_fp_command #(
    parameter int unsigned OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [31:0]         op_a,
    output logic [31:0]         op_b,
    output logic [OPCODE_W-1:0] opcode,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    input  logic                result_valid,
    output logic                irq
);

    // Register word addresses
    localparam logic [1:0] AddrOpa    = 2'd0;
    localparam logic [1:0] AddrOpb    = 2'd1;
    localparam logic [1:0] AddrCtrl   = 2'd2;
    localparam logic [1:0] AddrStatus = 2'd3;

    // Command tracking states
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [31:0]         opa_q, opa_d;
    logic [31:0]         opb_q, opb_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                irq_en_q, irq_en_d;
    logic [31:0]         readdata_q, readdata_d;

    logic wr_en;
    logic busy;
    logic start;
    logic done_set, done_clr;
    logic overrun_set, overrun_clr;

    // Only some writedata bits carry meaning; the rest are don't-care.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr_en = chipselect && !write_n;
    assign busy  = (state_q != StIdle);

    // Start is only honoured from IDLE; a start while busy is an overrun.
    assign start = wr_en && (address == AddrCtrl) && writedata[31] && !busy;

    assign done_set = (state_q == StWait) && result_valid;
    assign done_clr = wr_en && (address == AddrStatus) && writedata[1];

    // Any OPA/OPB/CTRL write while busy is dropped and flagged.
    assign overrun_set = wr_en && busy && (address != AddrStatus);
    assign overrun_clr = wr_en && (address == AddrStatus) && writedata[3];

    // Operand and opcode registers: writable only while idle
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        opcode_d = opcode_q;
        if (wr_en && !busy) begin
            unique case (address)
                AddrOpa:  opa_d    = writedata;
                AddrOpb:  opb_d    = writedata;
                AddrCtrl: opcode_d = writedata[OPCODE_W-1:0];
                default:  ;
            endcase
        end
    end

    // Status flags; a set event on the same edge beats a W1C clear.
    always_comb begin
        done_d    = done_q;
        overrun_d = overrun_q;
        irq_en_d  = irq_en_q;

        if (done_set) begin
            done_d = 1'b1;
        end else if (done_clr) begin
            done_d = 1'b0;
        end

        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (wr_en && (address == AddrStatus)) begin
            irq_en_d = writedata[2];
        end
    end

    // Command tracking FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (cmd_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (result_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read mux, captured every cycle regardless of read strobes
    always_comb begin
        readdata_d = 32'h0;
        unique case (address)
            AddrOpa:    readdata_d = opa_q;
            AddrOpb:    readdata_d = opb_q;
            AddrCtrl:   readdata_d = 32'(opcode_q);
            AddrStatus: readdata_d = {28'h0, overrun_q, irq_en_q, done_q, busy};
            default:    readdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            opa_q      <= 32'h0;
            opb_q      <= 32'h0;
            opcode_q   <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            readdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            opcode_q   <= opcode_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            irq_en_q   <= irq_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata  = readdata_q;
    assign op_a      = opa_q;
    assign op_b      = opb_q;
    assign opcode    = opcode_q;
    assign cmd_valid = (state_q == StIssue);
    assign irq       = done_q && irq_en_q;

endmodule
